strobe_decoder: RTL and testbench

- Parametrised, registered successor to the combinational 2-to-4 active-low decoder.
- Turns a select-code request into a timed, active-low one-hot strobe on one of 2**SEL_W lines.
- Generates memory-mapped I/O and register-file device selects for the LC-3 datapath.
- Adds a valid/ready handshake, pulse-length or latched mode, early release, and a guaranteed break-before-make gap between selections.

---
 rtl/lc3_strobe_pkg.sv | 32 +++
 rtl/onehot_decoder_n.sv | 24 ++
 rtl/strobe_decoder.sv | 120 ++++++++++++
 tb/tb_strobe_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_strobe_pkg.sv
// ============================================================================
// Module   : lc3_strobe_pkg
// Brief    : State encoding and length clamp shared by the LC-3 strobe decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lc3_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Zero-length requests still produce one strobe cycle; long ones saturate.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max);
        int unsigned l;
        if (len == 0)
            l = 1;
        else if (len > max)
            l = max;
        else
            l = len;
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_n.sv
// ============================================================================
// Module   : onehot_decoder_n
// Brief    : Combinational active-low one-hot decoder; all ones when disabled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module onehot_decoder_n #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [2**SEL_W-1:0] out_n
);

    always_comb begin
        out_n = '1;
        if (en)
            out_n[sel] = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/strobe_decoder.sv
// ============================================================================
// Module   : strobe_decoder
// Brief    : Registered active-low device-select strobe with handshake,
//            pulse/latched modes, early release and a break-before-make gap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module strobe_decoder
    import lc3_strobe_pkg::*;
#(
    parameter int  SEL_W   = 2,
    parameter int  MAX_LEN = 4,
    localparam int N_OUT   = 2**SEL_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_latch,
    // "release" is a reserved word in SystemVerilog, hence this name.
    input  logic             strobe_release,
    output logic [N_OUT-1:0] out_n,
    output logic             active,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_on_nxt;
    logic             w_done_nxt;
    logic [N_OUT-1:0] w_dec_out_n;
    logic [N_OUT-1:0] r_out_n;
    logic             r_active;
    logic             r_done;

    assign req_ready = (r_state == ST_IDLE);
    assign out_n     = r_out_n;
    assign active    = r_active;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_out_n  <= '1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_out_n  <= w_dec_out_n;
            r_active <= w_on_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // w_on_nxt describes the cycle after the edge, so the strobe flops
    // switch on the same edge as the state and never pass through a decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_on_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_sel_nxt   = req_sel;
                    w_cnt_nxt   = LEN_W'(clamp_len(32'(req_len), MAX_LEN) - 32'd1);
                    w_on_nxt    = 1'b1;
                    w_state_nxt = req_latch ? ST_HOLD : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (strobe_release || (r_cnt == '0)) begin
                    w_state_nxt = ST_GAP;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    w_on_nxt  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (strobe_release) begin
                    w_state_nxt = ST_GAP;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_on_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    onehot_decoder_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel   (w_sel_nxt),
        .en    (w_on_nxt),
        .out_n (w_dec_out_n)
    );

endmodule

`default_nettype wire

// File: tb/tb_strobe_decoder.sv
// ============================================================================
// Module   : tb_strobe_decoder
// Brief    : Self-checking bench for strobe_decoder (4-line and 8-line builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_strobe_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    // instance A: SEL_W=2, MAX_LEN=4
    logic       a_valid = 1'b0, a_latch = 1'b0, a_rel = 1'b0;
    logic [1:0] a_sel = '0;
    logic [2:0] a_len = '0;
    logic       a_ready, a_active, a_done;
    logic [3:0] a_out_n;
    // instance B: SEL_W=3, MAX_LEN=1
    logic       b_valid = 1'b0, b_latch = 1'b0, b_rel = 1'b0;
    logic [2:0] b_sel = '0;
    logic [0:0] b_len = '0;
    logic       b_ready, b_active, b_done;
    logic [7:0] b_out_n;

    int total = 0;
    int bad   = 0;

    strobe_decoder #(.SEL_W(2), .MAX_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_sel(a_sel), .req_len(a_len), .req_latch(a_latch),
        .strobe_release(a_rel), .out_n(a_out_n), .active(a_active), .done(a_done)
    );

    strobe_decoder #(.SEL_W(3), .MAX_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_sel(b_sel), .req_len(b_len), .req_latch(b_latch),
        .strobe_release(b_rel), .out_n(b_out_n), .active(b_active), .done(b_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a strobe is either on (with cycles left, or open-ended
    // when latched), in its one-cycle gap, or idle and ready for a request.
    bit m_on[2], m_gap[2], m_latch[2];
    int m_sel[2], m_left[2];

    task automatic mstep(input int k, input bit v, input int s, input int len,
                         input bit lat, input bit rel, input int mx);
        if (m_on[k]) begin
            if (rel || (!m_latch[k] && m_left[k] == 1)) begin
                m_on[k]  = 1'b0;
                m_gap[k] = 1'b1;
            end else if (!m_latch[k]) begin
                m_left[k]--;
            end
        end else if (m_gap[k]) begin
            m_gap[k] = 1'b0;
        end else if (v) begin
            m_on[k]    = 1'b1;
            m_sel[k]   = s;
            m_latch[k] = lat;
            m_left[k]  = (len == 0) ? 1 : (len > mx) ? mx : len;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_on[k] = 1'b0; m_gap[k] = 1'b0; m_latch[k] = 1'b0;
                m_sel[k] = 0;   m_left[k] = 0;
            end
        end else begin
            mstep(0, a_valid, int'(a_sel), int'(a_len), a_latch, a_rel, 4);
            mstep(1, b_valid, int'(b_sel), int'(b_len), b_latch, b_rel, 1);
        end
    end

    function automatic logic [7:0] exp_out(input int k, input logic [7:0] mask);
        logic [7:0] one;
        one = 8'd1 << m_sel[k];
        return m_on[k] ? (mask & ~one) : mask;
    endfunction

    always @(negedge clk) begin
        chk("a_out_n",  64'(a_out_n),  64'(exp_out(0, 8'h0f)));
        chk("a_active", 64'(a_active), 64'(m_on[0]));
        chk("a_done",   64'(a_done),   64'(m_gap[0]));
        chk("a_ready",  64'(a_ready),  64'(!m_on[0] && !m_gap[0]));
        chk("b_out_n",  64'(b_out_n),  64'(exp_out(1, 8'hff)));
        chk("b_active", 64'(b_active), 64'(m_on[1]));
        chk("b_done",   64'(b_done),   64'(m_gap[1]));
        chk("b_ready",  64'(b_ready),  64'(!m_on[1] && !m_gap[1]));
    end

    // Pulse request on A; counts low cycles until the gap appears.
    task automatic measure(input logic [1:0] s, input logic [2:0] len,
                           input int exp_len, input string name);
        int n;
        bit ended;
        n = 0;
        ended = 1'b0;
        a_valid = 1'b1; a_sel = s; a_len = len; a_latch = 1'b0;
        @(posedge clk); #2 a_valid = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk);
            if (a_out_n != 4'hf) n++;
            else ended = 1'b1;
        end
        chk(name, 64'(n), 64'(exp_len));
        chk({name, "_done"}, 64'(a_done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [6];
        logic [7:0] bexp;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_n",  64'(a_out_n),  64'hf);
        chk("rst_ready",  64'(a_ready),  64'd1);
        chk("rst_active", 64'(a_active), 64'd0);
        chk("rst_done",   64'(a_done),   64'd0);

        // sel=2, len=3 pulse
        a_valid = 1'b1; a_sel = 2'd2; a_len = 3'd3; a_latch = 1'b0;
        @(posedge clk); #2 a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("pulse3_low", 64'(a_out_n), 64'b1011);
        end
        @(negedge clk);
        chk("pulse3_gap",  64'(a_out_n), 64'hf);
        chk("pulse3_done", 64'(a_done),  64'd1);
        @(negedge clk);
        chk("pulse3_ready", 64'(a_ready), 64'd1);
        chk("pulse3_idle",  64'(a_done),  64'd0);

        measure(2'd1, 3'd0, 1, "len0");
        measure(2'd0, 3'd7, 4, "len7");
        measure(2'd3, 3'd4, 4, "len4");

        // latched sel=1, release after 10 cycles
        a_valid = 1'b1; a_sel = 2'd1; a_len = 3'd0; a_latch = 1'b1;
        @(posedge clk); #2 a_valid = 1'b0; a_latch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); chk("hold_low", 64'(a_out_n), 64'b1101);
        end
        a_rel = 1'b1;
        @(posedge clk); #2 a_rel = 1'b0;
        @(negedge clk);
        chk("hold_rel",  64'(a_out_n), 64'hf);
        chk("hold_done", 64'(a_done),  64'd1);
        @(negedge clk);
        chk("hold_ready", 64'(a_ready), 64'd1);

        // early release of a len=4 pulse in its 2nd cycle
        a_valid = 1'b1; a_sel = 2'd3; a_len = 3'd4; a_latch = 1'b0;
        @(posedge clk); #2 a_valid = 1'b0;
        @(negedge clk); chk("early_c1", 64'(a_out_n), 64'b0111);
        @(negedge clk); chk("early_c2", 64'(a_out_n), 64'b0111);
        a_rel = 1'b1;
        @(posedge clk); #2 a_rel = 1'b0;
        @(negedge clk);
        chk("early_off",  64'(a_out_n), 64'hf);
        chk("early_done", 64'(a_done),  64'd1);
        @(negedge clk);

        // back-to-back with req_valid held high
        a_valid = 1'b1; a_sel = 2'd0; a_len = 3'd1; a_latch = 1'b0;
        @(posedge clk); #2 a_sel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); seq[i] = a_out_n;
        end
        a_valid = 1'b0;
        chk("b2b_first", 64'(seq[0]), 64'b1110);
        chk("b2b_gap",   64'(seq[1]), 64'hf);
        chk("b2b_idle",  64'(seq[2]), 64'hf);
        chk("b2b_next",  64'(seq[3]), 64'b0111);
        @(negedge clk);

        // reset in the middle of a latched strobe
        a_valid = 1'b1; a_sel = 2'd2; a_latch = 1'b1;
        @(posedge clk); #2 a_valid = 1'b0; a_latch = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_low", 64'(a_out_n), 64'b1011);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out",    64'(a_out_n),  64'hf);
        chk("midrst_active", 64'(a_active), 64'd0);
        chk("midrst_done",   64'(a_done),   64'd0);
        @(negedge clk);
        chk("midrst_done2", 64'(a_done), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(a_ready), 64'd1);
        chk("midrst_idle",  64'(a_done),  64'd0);

        // 8-line build, MAX_LEN=1: every code drives only its own line
        for (int c = 0; c < 8; c++) begin
            b_valid = 1'b1; b_sel = 3'(c); b_len = 1'($urandom_range(1));
            @(posedge clk); #2 b_valid = 1'b0;
            bexp = ~(8'd1 << c);
            @(negedge clk); chk("sweep_low", 64'(b_out_n), 64'(bexp));
            @(negedge clk);
            chk("sweep_gap",  64'(b_out_n), 64'hff);
            chk("sweep_done", 64'(b_done),  64'd1);
            @(negedge clk);
        end

        // random traffic on both builds
        repeat (600) begin
            @(posedge clk); #2;
            a_valid = ($urandom_range(2) == 0);
            a_sel   = 2'($urandom_range(3));
            a_len   = 3'($urandom_range(7));
            a_latch = 1'($urandom_range(1));
            a_rel   = ($urandom_range(4) == 0);
            b_valid = ($urandom_range(1) == 0);
            b_sel   = 3'($urandom_range(7));
            b_len   = 1'($urandom_range(1));
            b_latch = ($urandom_range(3) == 0);
            b_rel   = ($urandom_range(3) == 0);
        end
        @(posedge clk); #2;
        a_valid = 1'b0; a_rel = 1'b0; b_valid = 1'b0; b_rel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
